// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: 2-bit saturating BHT predictor plus EX-stage branch/jump resolution.
// Define BPU_STATS_EN to build the branch and mispredict counters.
module branch_resolve_unit #(
    parameter int BHT_IDX_W = 6
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] ifpc_i,
    output logic        pred_taken_o,
    input  logic        idex_branch_i,
    input  logic        idex_jump_i,
    input  logic        idex_pred_taken_i,
    input  logic        br_taken_i,
    input  logic [31:0] idex_pc_i,
    input  logic [31:0] idex_br_target_i,
    output logic [1:0]  nexttype_o,
    output logic [31:0] correct_pc_o,
    output logic [31:0] branch_count_o,
    output logic [31:0] miss_count_o
);
    localparam int N = 1 << BHT_IDX_W;
    logic [1:0] bht_q [N];
    logic [BHT_IDX_W-1:0] if_idx, ex_idx;
    logic [1:0] ctr, ctr_d;
    logic upd;
    logic unused_pc_bits;
    assign if_idx = ifpc_i[BHT_IDX_W+1:2];
    assign ex_idx = idex_pc_i[BHT_IDX_W+1:2];
    assign unused_pc_bits = ^{ifpc_i[31:BHT_IDX_W+2], ifpc_i[1:0]};
    // Read returns the pre-edge counter; no bypass from a same-cycle update.
    assign pred_taken_o = bht_q[if_idx][1];
    assign nexttype_o = idex_jump_i ? 2'b11 :
                        !idex_branch_i ? 2'b00 :
                        (br_taken_i == idex_pred_taken_i) ? 2'b01 : 2'b10;
    assign correct_pc_o = br_taken_i ? idex_br_target_i : idex_pc_i + 32'd4;
    assign upd = idex_branch_i & ~idex_jump_i;
    assign ctr = bht_q[ex_idx];
    always_comb begin
        ctr_d = br_taken_i ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                           : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
    end
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N; i++) bht_q[i] <= 2'b10;
        end else if (upd) begin
            bht_q[ex_idx] <= ctr_d;
        end
    end
`ifdef BPU_STATS_EN
    logic [31:0] branch_count_q, miss_count_q;
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            if (upd) branch_count_q <= branch_count_q + 32'd1;
            if (nexttype_o == 2'b10) miss_count_q <= miss_count_q + 32'd1;
        end
    end
    assign branch_count_o = branch_count_q;
    assign miss_count_o   = miss_count_q;
`else
    assign branch_count_o = '0;
    assign miss_count_o   = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with hand-computed expectations for branch_resolve_unit.
module tb_branch_resolve_unit;
`ifdef BPU_STATS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ifpc;
    logic        pred_taken;
    logic        idex_branch, idex_jump, idex_pred_taken, br_taken;
    logic [31:0] idex_pc, idex_br_target;
    logic [1:0]  nexttype;
    logic [31:0] correct_pc, branch_count, miss_count;
    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit dut (
        .clk_i(clk), .rstn_i(rstn), .ifpc_i(ifpc), .pred_taken_o(pred_taken),
        .idex_branch_i(idex_branch), .idex_jump_i(idex_jump),
        .idex_pred_taken_i(idex_pred_taken), .br_taken_i(br_taken),
        .idex_pc_i(idex_pc), .idex_br_target_i(idex_br_target),
        .nexttype_o(nexttype), .correct_pc_o(correct_pc),
        .branch_count_o(branch_count), .miss_count_o(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic br, input logic jp, input logic pt, input logic bt,
                      input logic [31:0] pc, input logic [31:0] tgt);
        idex_branch = br; idex_jump = jp; idex_pred_taken = pt; br_taken = bt;
        idex_pc = pc; idex_br_target = tgt;
        #1;
    endtask

    task automatic stats(input string tag, input int b, input int m);
        check({tag, "_bcnt"}, branch_count, 32'(ST * b));
        check({tag, "_mcnt"}, miss_count, 32'(ST * m));
    endtask

    initial begin
        rstn = 1'b0; ifpc = 32'h0;
        // a mispredicted not-taken branch held during reset must not update anything
        ex(1, 0, 1, 0, 32'h40, 32'h200);
        tick(); tick();
        rstn = 1'b1;
        ex(0, 0, 0, 0, 32'h0, 32'h0);
        for (int a = 0; a < 64; a++) begin
            ifpc = 32'(a * 4);
            #1;
            check($sformatf("reset_pred_%0h", a * 4), {31'b0, pred_taken}, 32'd1);
        end
        stats("reset", 0, 0);

        ifpc = 32'h40;
        ex(1, 0, 1, 0, 32'h40, 32'h200);
        check("pt_nt_type", {30'b0, nexttype}, 32'd2);
        check("pt_nt_cpc", correct_pc, 32'h44);
        tick();
        ex(0, 0, 0, 0, 32'h0, 32'h0);
        check("pt_nt_pred_after", {31'b0, pred_taken}, 32'd0);
        stats("pt_nt", 1, 1);

        ex(1, 0, 0, 1, 32'h60, 32'h100);
        check("pn_t_type", {30'b0, nexttype}, 32'd2);
        check("pn_t_cpc", correct_pc, 32'h100);
        tick();
        stats("pn_t", 2, 2);

        ifpc = 32'h80;
        for (int k = 0; k < 4; k++) begin
            ex(1, 0, 1, 1, 32'h80, 32'h300);
            check($sformatf("sat_t%0d_type", k), {30'b0, nexttype}, 32'd1);
            tick();
        end
        ex(1, 0, 1, 0, 32'h80, 32'h300);
        check("sat_nt_type", {30'b0, nexttype}, 32'd2);
        tick();
        ex(0, 0, 0, 0, 32'h0, 32'h0);
        check("sat_pred", {31'b0, pred_taken}, 32'd1);
        stats("sat", 7, 3);

        // counter at 0x80 is now 10, so a leaked not-taken update would flip the prediction
        ex(1, 1, 1, 0, 32'h80, 32'h300);
        check("jmp_type", {30'b0, nexttype}, 32'd3);
        check("jmp_cpc_nt", correct_pc, 32'h84);
        tick();
        ex(1, 1, 0, 1, 32'h80, 32'h300);
        check("jmp_type2", {30'b0, nexttype}, 32'd3);
        check("jmp_cpc_t", correct_pc, 32'h300);
        tick();
        ex(0, 0, 0, 0, 32'h0, 32'h0);
        check("jmp_bht_kept", {31'b0, pred_taken}, 32'd1);
        stats("jmp", 7, 3);

        ifpc = 32'h10;
        ex(1, 0, 1, 0, 32'h10, 32'h400);
        check("same_idx_old", {31'b0, pred_taken}, 32'd1);
        tick();
        ex(0, 0, 0, 0, 32'h0, 32'h0);
        check("same_idx_new", {31'b0, pred_taken}, 32'd0);
        check("bubble_type", {30'b0, nexttype}, 32'd0);
        check("bubble_cpc", correct_pc, 32'h4);
        stats("same_idx", 8, 4);

        ifpc = 32'hFC;
        ex(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h500);
        check("wrap_cpc", correct_pc, 32'h0);
        check("wrap_type", {30'b0, nexttype}, 32'd1);
        tick();
        ex(0, 0, 0, 0, 32'h0, 32'h0);
        check("wrap_pred", {31'b0, pred_taken}, 32'd0);
        stats("wrap", 9, 4);

        rstn = 1'b0;
        ex(1, 0, 1, 0, 32'h20, 32'h0);
        tick();
        rstn = 1'b1;
        ex(0, 0, 0, 0, 32'h0, 32'h0);
        ifpc = 32'h20; #1;
        check("rst2_pred_20", {31'b0, pred_taken}, 32'd1);
        ifpc = 32'h40; #1;
        check("rst2_pred_40", {31'b0, pred_taken}, 32'd1);
        ifpc = 32'h10; #1;
        check("rst2_pred_10", {31'b0, pred_taken}, 32'd1);
        stats("rst2", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Branch prediction and resolution block for the pipelined CPU. It keeps a table of 2-bit saturating counters that supply a taken/not-taken prediction for the fetch PC. It resolves the branch or jump in EX against that prediction. It drives the Nexttype code and the recovery PC that the hazard detection unit and the PC mux consume. It is the producer of the Nexttype interface.

## Interface
- BHT_IDX_W, 6, log2 of BHT entries (default 64 entries); index = PC[BHT_IDX_W+1:2]
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, synchronous, active-low
- IFPC  in  32  PC of the instruction currently in IF
- PredTaken  out  1  prediction for IFPC; combinational, = BHT[idx(IFPC)][1]
- IDEXBranch  in  1  instruction in EX is a conditional branch (beq/bne); 0 for a bubble
- IDEXJump  in  1  instruction in EX is j/jal/jr; 0 for a bubble
- IDEXPredTaken  in  1  PredTaken value carried down the pipeline with this instruction
- BrTaken  in  1  branch condition result from the EX ALU
- IDEXPC  in  32  PC of the instruction in EX (not PC+4)
- IDEXBrTarget  in  32  computed branch target of the instruction in EX
- Nexttype  out  2  00 PCPlus4, 01 Branch (predicted correctly), 10 BranchWrong, 11 Jump
- CorrectPC  out  32  recovery PC; PC mux input selected by PCSrc=10
- BranchCount  out  32  resolved branches (stats)
- MissCount  out  32  mispredicted branches (stats)

## Operation
- Nexttype is decoded combinationally from the EX inputs, with this priority:
  - IDEXJump=1 -> 11, regardless of IDEXBranch.
  - Else IDEXBranch=1 and BrTaken==IDEXPredTaken -> 01.
  - Else IDEXBranch=1 -> 10.
  - Else -> 00.
- CorrectPC = BrTaken ? IDEXBrTarget : IDEXPC+4.
  - The sum is 32-bit and wraps mod 2^32.
  - When Nexttype is not 10, CorrectPC still follows this formula; consumers ignore it.
- BHT update happens only when IDEXBranch=1 and IDEXJump=0, at index idx(IDEXPC):
  - BrTaken=1: counter +1, saturating at 11.
  - BrTaken=0: counter -1, saturating at 00.
- Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. The prediction is the counter MSB.
- Jumps and non-branches never modify the BHT.
- PredTaken reads the BHT combinationally and returns the pre-edge value. There is no write-to-read bypass.
  - When idx(IFPC)==idx(IDEXPC) during an update cycle, PredTaken shows the old counter.
- Aliasing between PCs that share an index is accepted; there are no tags.

## Timing
- Reset, while rstn=0 at a rising edge:
  - All BHT entries are set to 10 (weak taken).
  - BranchCount and MissCount are set to 0.
  - No update occurs that cycle even if IDEXBranch=1.
- After reset, PredTaken=1 for every IFPC. Nexttype and CorrectPC follow the inputs immediately; they have no reset value of their own.
- Nexttype and CorrectPC have zero latency: they are valid in the same cycle as the EX inputs.
- A BHT write takes effect at the rising edge that ends the EX cycle. It is visible to PredTaken from the next cycle.
- One update per cycle at most. Each EX instruction is presented for exactly one cycle.
  - Bubbles inserted by IDEXFlush arrive with IDEXBranch=IDEXJump=0 and therefore cause no update.
- Reset asserted mid-operation overrides any same-cycle update.

## Configuration
- BPU_STATS_EN defined:
  - BranchCount increments by 1 at each edge with a BHT update.
  - MissCount increments by 1 at each edge where Nexttype=10.
  - Both wrap from 32'hFFFFFFFF to 0.
- BPU_STATS_EN undefined: both outputs are tied to 32'h0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Reset check: hold rstn=0 for 2 cycles, then sweep IFPC=0x00,0x04..0xFC.
  - Required: PredTaken=1 for every address; BranchCount=MissCount=0.
- Predicted taken, not taken:
  - Stimulus: IDEXBranch=1, IDEXPredTaken=1, BrTaken=0, IDEXPC=0x40.
  - Required: Nexttype=10 and CorrectPC=0x44.
  - Required next cycle: PredTaken for IFPC=0x40 becomes 0 (counter 10->01).
  - With BPU_STATS_EN: MissCount=1.
- Predicted not taken, taken:
  - Stimulus: IDEXPredTaken=0, BrTaken=1, IDEXBrTarget=0x100.
  - Required: Nexttype=10, CorrectPC=0x100.
- Saturation:
  - Stimulus: four taken updates at IDEXPC=0x80, then one not-taken update.
  - Required: PredTaken for IFPC=0x80 stays 1 (counter 11->10); Nexttype=01 on each correctly predicted branch.
- Jump priority and same-index read:
  - Stimulus: IDEXJump=1 and IDEXBranch=1 together.
    - Required: Nexttype=11 and the BHT is unchanged.
  - Stimulus: a not-taken update at IDEXPC=0x10 while IFPC=0x10, counter at 10.
    - Required: PredTaken=1 that cycle and 0 the next.
- Wrap cases:
  - Stimulus: IDEXPC=0xFFFFFFFC with BrTaken=0.
    - Required: CorrectPC=0x00000000.
  - Stimulus: BPU_STATS_EN with BranchCount preset near 0xFFFFFFFF.
    - Required: the count wraps to 0.
